ps2_mouse_rx: RTL
=================

Name: ps2_mouse_rx

Overview:
Hardware PS/2 mouse receiver. It samples the mouse's PS2_CLK/PS2_DAT lines, assembles 3-byte movement packets, and produces the same MouseX/MouseY/MouseButtons triple the cursor and color_mapper blocks already consume. It is the producer end of the interface that the USB/NIOS path currently feeds. It sits at the top level beside the SoC, and a top-level mux selects which source drives the cursor. It is receive-only; it never drives the PS/2 lines.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples required before the filtered PS2_CLK changes level
TIMEOUT_CYCLES, 100000, Clk cycles (2 ms at 50 MHz) without a filtered falling edge before an in-progress frame or packet is abandoned

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous, active-low reset
PS2_CLK  in  1  mouse clock, asynchronous
PS2_DAT  in  1  mouse data, asynchronous
MouseX  out  8  signed X delta, saturated, positive = right
MouseY  out  8  signed Y delta, saturated, positive = down (screen convention)
MouseButtons  out  8  {5'b0, middle, right, left}
packet_valid  out  1  one-cycle pulse; new MouseX/MouseY/MouseButtons present
frame_error  out  1  one-cycle pulse on start, parity, stop, or timeout error

Behaviour:
- Reset (async, Reset_n=0): MouseX=0, MouseY=0, MouseButtons=0, packet_valid=0, frame_error=0, FSM=IDLE, byte index=0, filters cleared to 1 (lines idle high), timeout counter=0.
- Input conditioning:
  - Both lines pass through 2-FF synchronizers.
  - PS2_CLK is then glitch-filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is the only sample strobe. PS2_DAT (synchronized) is sampled on that cycle.
- Frame FSM (11 bits, LSB first):
  - IDLE: on strobe, if data=0 go to DATA with bit count 0. If data=1, pulse frame_error and stay in IDLE.
  - DATA: shift in 8 bits; after the 8th go to PARITY.
  - PARITY: capture the bit; odd parity over 8 data bits + parity bit is required. Go to STOP.
  - STOP: data must be 1 and parity must be ok. Then the byte is accepted and the FSM returns to IDLE. Otherwise pulse frame_error, set byte index=0, return to IDLE.
- Packet assembly:
  - Byte index 0 is the status byte (b0). b0[3] must be 1. If b0[3]=0 the byte is discarded silently (index stays 0) so the receiver can resync.
  - Index 1 is the X byte, index 2 is the Y byte.
  - On acceptance of byte 2, registered outputs update one Clk cycle later, packet_valid pulses in that same cycle, and index returns to 0.
  - Outputs hold their values between packets.
- Arithmetic:
  - dx = {b0[4], Xbyte} (9-bit signed). dy = {b0[5], Ybyte}.
  - MouseX = sat8(dx). MouseY = sat8(-dy), computed in 10 bits.
  - sat8 clamps to [-128, 127].
  - Overflow: if b0[6]=1, MouseX = b0[4] ? -128 : 127. If b0[7]=1, MouseY = b0[5] ? 127 : -128.
  - MouseButtons = {5'b0, b0[2], b0[1], b0[0]}.
- Timeout:
  - The counter runs while FSM≠IDLE or byte index≠0, and clears on every strobe.
  - On reaching TIMEOUT_CYCLES: FSM=IDLE, index=0, frame_error pulses, and outputs are unchanged.
- Simultaneous events: an error and a packet completion cannot coincide. Timeout takes priority over a strobe arriving in the same cycle; that strobe is ignored.
- Reset mid-frame: the partial byte and partial packet are discarded; no pulse occurs after release.

Test Plan:
- Packet 0x09, 0x05, 0x03, each framed with correct odd parity, PS2_CLK period 80 µs -> exactly one packet_valid pulse; MouseX=0x05, MouseY=0xFD (-3), MouseButtons=0x01; frame_error never asserts.
- Packet 0x38, 0xF6, 0xFB -> MouseX=0xF6 (-10), MouseY=0x05 (+5), MouseButtons=0x00.
- Packet 0x48, 0x10, 0x80 -> MouseX=0x7F (X overflow, positive sign). dy=+128 -> MouseY=0x80 (-128, boundary without saturation).
- Second byte sent with parity inverted -> single frame_error pulse, no packet_valid, outputs keep the previous values. The following good packet 0x0A, 0x01, 0x01 -> MouseX=0x01, MouseY=0xFF, MouseButtons=0x02.
- Misaligned byte 0x00, then packet 0x0C, 0x00, 0x00 -> 0x00 is discarded without error; one packet_valid with MouseButtons=0x04.
- Five bits of a frame, then PS2_CLK held high for >TIMEOUT_CYCLES -> frame_error pulse and FSM back to IDLE; the next full packet decodes correctly. Separately, Reset_n=0 mid-byte -> all outputs 0 immediately, and no pulses follow release.

Source files
------------

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: receive-only PS/2 mouse decoder.
// Samples PS2_CLK/PS2_DAT, deglitches the clock, frames 11-bit bytes
// (start, 8 data LSB first, odd parity, stop), assembles 3-byte movement
// packets and presents the cursor-side MouseX/MouseY/MouseButtons triple.
// Ports:
//   Clk, Reset_n     system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DAT asynchronous mouse lines (never driven)
//   MouseX, MouseY   saturated signed deltas (Y positive = down)
//   MouseButtons     {5'b0, middle, right, left}
//   packet_valid     one-cycle pulse with each new output triple
//   frame_error      one-cycle pulse on start/parity/stop/timeout error
module ps2_mouse_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] MouseX,
   output logic [7:0] MouseY,
   output logic [7:0] MouseButtons,
   output logic       packet_valid,
   output logic       frame_error
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
      if (v > 10'sd127)       return 8'sh7F;
      else if (v < -10'sd128) return 8'sh80;
      else                    return v[7:0];
   endfunction

   // Input conditioning: 2-FF synchronizers, then clock glitch filter
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_prev_q;
   logic [FW-1:0] fcnt_q;
   logic          strobe;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
      end else begin
         clk_s1_q    <= PS2_CLK;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= PS2_DAT;
         dat_s2_q    <= dat_s1_q;
         filt_prev_q <= filt_q;
         // fcnt_q counts consecutive samples disagreeing with the filtered level
         if (clk_s2_q == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= clk_s2_q;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + FW'(1);
         end
      end
   end

   assign strobe = filt_prev_q & ~filt_q;

   // Frame FSM, packet assembly and timeout
   state_t            state_q, state_d;
   logic [2:0]        bcnt_q, bcnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic [1:0]        idx_q, idx_d;
   logic [6:0]        st_q, st_d;   // status byte minus its always-1 bit 3
   logic [7:0]        bx_q, bx_d;
   logic [TW-1:0]     to_q, to_d;
   logic signed [7:0] mx_q, mx_d, my_q, my_d;
   logic [2:0]        btn_q, btn_d;
   logic              pv_q, pv_d, err_q, err_d;
   logic              active, timeout;
   logic signed [9:0] dx, dy, ndy;

   // st_q = {ovf_y, ovf_x, sign_y, sign_x, middle, right, left}
   assign dx  = {{2{st_q[3]}}, bx_q};
   assign dy  = {{2{st_q[4]}}, shift_q};
   assign ndy = -dy;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      idx_d   = idx_q;
      st_d    = st_q;
      bx_d    = bx_q;
      mx_d    = mx_q;
      my_d    = my_q;
      btn_d   = btn_q;
      pv_d    = 1'b0;
      err_d   = 1'b0;
      active  = (state_q != S_IDLE) || (idx_q != 2'd0);
      timeout = active && (to_q == TW'(TIMEOUT_CYCLES - 1));
      to_d    = active ? to_q + TW'(1) : '0;

      // A timeout wins over a strobe landing in the same cycle
      if (timeout) begin
         state_d = S_IDLE;
         idx_d   = 2'd0;
         err_d   = 1'b1;
         to_d    = '0;
      end else if (strobe) begin
         to_d = '0;
         case (state_q)
            S_IDLE: begin
               if (!dat_s2_q) begin
                  state_d = S_DATA;
                  bcnt_d  = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
            S_DATA: begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               if (bcnt_q == 3'd7) state_d = S_PARITY;
               else                bcnt_d  = bcnt_q + 3'd1;
            end
            S_PARITY: begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (dat_s2_q && (^{shift_q, par_q})) begin
                  case (idx_q)
                     2'd0: begin
                        // Bytes without bit 3 set cannot be status bytes; drop to resync
                        if (shift_q[3]) begin
                           st_d  = {shift_q[7:4], shift_q[2:0]};
                           idx_d = 2'd1;
                        end
                     end
                     2'd1: begin
                        bx_d  = shift_q;
                        idx_d = 2'd2;
                     end
                     default: begin
                        mx_d  = st_q[5] ? (st_q[3] ? 8'sh80 : 8'sh7F) : sat8(dx);
                        my_d  = st_q[6] ? (st_q[4] ? 8'sh7F : 8'sh80) : sat8(ndy);
                        btn_d = st_q[2:0];
                        pv_d  = 1'b1;
                        idx_d = 2'd0;
                     end
                  endcase
               end else begin
                  err_d = 1'b1;
                  idx_d = 2'd0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         idx_q   <= '0;
         st_q    <= '0;
         bx_q    <= '0;
         to_q    <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         btn_q   <= '0;
         pv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
         bx_q    <= bx_d;
         to_q    <= to_d;
         mx_q    <= mx_d;
         my_q    <= my_d;
         btn_q   <= btn_d;
         pv_q    <= pv_d;
         err_q   <= err_d;
      end
   end

   assign MouseX       = mx_q;
   assign MouseY       = my_q;
   assign MouseButtons = {5'b0, btn_q};
   assign packet_valid = pv_q;
   assign frame_error  = err_q;

endmodule
